// File: rtl/alu_dispatch_pkg.sv
// Shared constants and types for the ALU issue stage: opcodes, ALU command
// classes, FSM state encoding and flag bit positions.
package alu_dispatch_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [3:0] CMD_OP      = 4'd0;
  localparam logic [3:0] CMD_OPIMM   = 4'd1;
  localparam logic [3:0] CMD_LUI     = 4'd2;
  localparam logic [3:0] CMD_AUIPC   = 4'd3;
  localparam logic [3:0] CMD_BRANCH  = 4'd4;
  localparam logic [3:0] CMD_MEM     = 4'd5;
  localparam logic [3:0] CMD_ILLEGAL = 4'd15;

  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_NEGATIVE = 1;
  localparam int FLAG_CARRY    = 2;
  localparam int FLAG_OVERFLOW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_dispatch_decode.sv
// Combinational RV64I decode: instruction word plus register values and PC
// become ALU operands, command class, funct fields, rd and an illegal flag.
module alu_dispatch_decode
  import alu_dispatch_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [31:0]         instr_i,
  input  logic [WORDSIZE-1:0] rs1_i,
  input  logic [WORDSIZE-1:0] rs2_i,
  input  logic [WORDSIZE-1:0] pc_i,
  output logic [WORDSIZE-1:0] a_o,
  output logic [WORDSIZE-1:0] b_o,
  output logic [3:0]          cmd_o,
  output logic [2:0]          funct3_o,
  output logic [6:0]          funct7_o,
  output logic [4:0]          rd_o,
  output logic                illegal_o
);

  logic [6:0]          opcode;
  logic [2:0]          f3;
  logic [WORDSIZE-1:0] imm_i;
  logic [WORDSIZE-1:0] imm_s;
  logic [WORDSIZE-1:0] imm_u;
  logic [WORDSIZE-1:0] shamt;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign imm_i  = {{(WORDSIZE-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{(WORDSIZE-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u  = {{(WORDSIZE-32){instr_i[31]}}, instr_i[31:12], 12'b0};
  assign shamt  = {{(WORDSIZE-6){1'b0}}, instr_i[25:20]};

  always_comb begin
    a_o       = '0;
    b_o       = '0;
    cmd_o     = CMD_ILLEGAL;
    funct3_o  = 3'b000;
    funct7_o  = 7'b0000000;
    rd_o      = instr_i[11:7];
    illegal_o = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        cmd_o    = CMD_OP;
        a_o      = rs1_i;
        b_o      = rs2_i;
        funct3_o = f3;
        funct7_o = instr_i[31:25];
      end
      OPC_OPIMM: begin
        cmd_o    = CMD_OPIMM;
        a_o      = rs1_i;
        funct3_o = f3;
        // 6-bit shamt; bit 25 belongs to shamt, not to funct7
        if (f3 == 3'b001 || f3 == 3'b101) begin
          b_o      = shamt;
          funct7_o = {instr_i[31:26], 1'b0};
        end else begin
          b_o = imm_i;
        end
      end
      OPC_LUI: begin
        cmd_o = CMD_LUI;
        b_o   = imm_u;
      end
      OPC_AUIPC: begin
        cmd_o = CMD_AUIPC;
        a_o   = pc_i;
        b_o   = imm_u;
      end
      OPC_BRANCH: begin
        cmd_o    = CMD_BRANCH;
        a_o      = rs1_i;
        b_o      = rs2_i;
        funct7_o = 7'b0100000;
        rd_o     = 5'd0;
      end
      OPC_LOAD: begin
        cmd_o = CMD_MEM;
        a_o   = rs1_i;
        b_o   = imm_i;
      end
      OPC_STORE: begin
        cmd_o = CMD_MEM;
        a_o   = rs1_i;
        b_o   = imm_s;
        rd_o  = 5'd0;
      end
      default: begin
        illegal_o = 1'b1;
        rd_o      = 5'd0;
      end
    endcase
  end

endmodule

// File: rtl/alu_dispatch.sv
// Operand-side issue stage of the 64-bit ALU: IDLE -> EXEC -> DONE, one
// instruction in flight, operands held for one execute cycle.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [WORDSIZE-1:0] in_rs1,
  input  logic [WORDSIZE-1:0] in_rs2,
  input  logic [WORDSIZE-1:0] in_pc,
  output logic [WORDSIZE-1:0] alu_input_a,
  output logic [WORDSIZE-1:0] alu_input_b,
  output logic [3:0]          alu_cmd,
  output logic [2:0]          alu_funct3,
  output logic [6:0]          alu_funct7,
  input  logic [WORDSIZE-1:0] alu_result,
  input  logic [3:0]          alu_flags,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_result,
  output logic [3:0]          out_flags,
  output logic [4:0]          out_rd,
  output logic                out_illegal,
  output state_e              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and payload is stable while valid.

  state_e              state_q, state_d;
  logic [WORDSIZE-1:0] a_q, b_q, result_q;
  logic [3:0]          cmd_q, flags_q;
  logic [2:0]          f3_q;
  logic [6:0]          f7_q;
  logic [4:0]          rd_q;
  logic                illegal_q;

  logic [WORDSIZE-1:0] dec_a, dec_b;
  logic [3:0]          dec_cmd;
  logic [2:0]          dec_f3;
  logic [6:0]          dec_f7;
  logic [4:0]          dec_rd;
  logic                dec_illegal;
  logic                accept;

  alu_dispatch_decode #(.WORDSIZE(WORDSIZE)) u_decode (
    .instr_i   (in_instr),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .pc_i      (in_pc),
    .a_o       (dec_a),
    .b_o       (dec_b),
    .cmd_o     (dec_cmd),
    .funct3_o  (dec_f3),
    .funct7_o  (dec_f7),
    .rd_o      (dec_rd),
    .illegal_o (dec_illegal)
  );

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cmd_q     <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q       <= dec_a;
        b_q       <= dec_b;
        cmd_q     <= dec_cmd;
        f3_q      <= dec_f3;
        f7_q      <= dec_f7;
        rd_q      <= dec_rd;
        illegal_q <= dec_illegal;
      end
      // the ALU output is only meaningful for legal instructions
      if (state_q == ST_EXEC) begin
        result_q <= illegal_q ? '0 : alu_result;
        flags_q  <= illegal_q ? '0 : alu_flags;
      end
    end
  end

  assign alu_input_a = a_q;
  assign alu_input_b = b_q;
  assign alu_cmd     = cmd_q;
  assign alu_funct3  = f3_q;
  assign alu_funct7  = f7_q;
  assign out_valid   = (state_q == ST_DONE);
  assign out_result  = result_q;
  assign out_flags   = flags_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: decode vector table, scoreboard on the writeback
// handshake, plus reset-in-flight and backpressure/handoff sequences.
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  localparam int W  = 64;
  localparam int EW = W + 4 + 5 + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]  in_instr;
  logic [W-1:0] in_rs1, in_rs2, in_pc;
  logic [W-1:0] alu_input_a, alu_input_b, alu_result, out_result;
  logic [3:0]   alu_cmd, alu_flags, out_flags;
  logic [2:0]   alu_funct3;
  logic [6:0]   alu_funct7;
  logic [4:0]   out_rd;
  state_e       dbg_state;

  typedef struct {
    logic [31:0]  instr;
    logic [W-1:0] rs1, rs2, pc, a, b;
    logic [3:0]   cmd;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic [4:0]   rd;
    logic         ill;
  } vec_t;

  vec_t         vecs[12];
  logic [EW-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  alu_dispatch #(.WORDSIZE(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .alu_input_a(alu_input_a), .alu_input_b(alu_input_b), .alu_cmd(alu_cmd),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_rd(out_rd), .out_illegal(out_illegal),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Stand-in ALU: mixes every operand/control field into the result
  function automatic logic [W-1:0] alu_model(logic [W-1:0] a, logic [W-1:0] b,
                                             logic [6:0] f7, logic [2:0] f3, logic [3:0] cmd);
    return a + b + {{(W-14){1'b0}}, f7, f3, cmd};
  endfunction

  assign alu_result = alu_model(alu_input_a, alu_input_b, alu_funct7, alu_funct3, alu_cmd);
  assign alu_flags  = alu_result[3:0] ^ alu_result[W-1:W-4];

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] expect_of(vec_t v);
    logic [W-1:0] r;
    r = v.ill ? '0 : alu_model(v.a, v.b, v.f7, v.f3, v.cmd);
    return {r, v.ill ? 4'h0 : (r[3:0] ^ r[W-1:W-4]), v.rd, v.ill};
  endfunction

  // scoreboard: compare on every writeback handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result %h with empty queue", out_result);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_result", out_result, e[EW-1:10]);
        check("out_flags", W'(out_flags), W'(e[9:6]));
        check("out_rd", W'(out_rd), W'(e[5:1]));
        check("out_illegal", W'(out_illegal), W'(e[0]));
      end
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic drive(vec_t v);
    in_instr = v.instr;
    in_rs1   = v.rs1;
    in_rs2   = v.rs2;
    in_pc    = v.pc;
    in_valid = 1'b1;
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    in_instr = $urandom;
    in_rs1   = {$urandom, $urandom};
    in_rs2   = {$urandom, $urandom};
    in_pc    = {$urandom, $urandom};
  endtask

  task automatic check_alu(vec_t v, string tag);
    check({tag, "_alu_a"}, alu_input_a, v.a);
    check({tag, "_alu_b"}, alu_input_b, v.b);
    check({tag, "_alu_cmd"}, W'(alu_cmd), W'(v.cmd));
    check({tag, "_alu_f3"}, W'(alu_funct3), W'(v.f3));
    check({tag, "_alu_f7"}, W'(alu_funct7), W'(v.f7));
  endtask

  // one instruction from IDLE with out_ready=1: checks decode and 2-cycle latency
  task automatic run_vec(int i);
    drive(vecs[i]);
    exp_q.push_back(expect_of(vecs[i]));
    @(negedge clk);
    check($sformatf("v%0d_in_ready", i), W'(in_ready), 1);
    @(posedge clk); #1;
    scramble();
    @(negedge clk);
    check_alu(vecs[i], $sformatf("v%0d", i));
    check($sformatf("v%0d_state_exec", i), W'(dbg_state), W'(ST_EXEC));
    check($sformatf("v%0d_valid_early", i), W'(out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("v%0d_out_valid", i), W'(out_valid), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           instr          rs1                    rs2        pc                     a                      b                      cmd          f3    f7        rd     ill
    vecs[0]  = '{32'h002081B3, 64'd5,                 64'd7,     64'h1000,              64'd5,                 64'd7,                 CMD_OP,      3'd0, 7'h00,    5'd3,  1'b0};
    vecs[1]  = '{32'hFFF08093, 64'd100,               64'hDEAD,  64'h1004,              64'd100,               64'hFFFFFFFFFFFFFFFF,  CMD_OPIMM,   3'd0, 7'h00,    5'd1,  1'b0};
    vecs[2]  = '{32'h4280D093, 64'h8000000000000000,  64'd9,     64'h1008,              64'h8000000000000000,  64'd40,                CMD_OPIMM,   3'd5, 7'h20,    5'd1,  1'b0};
    vecs[3]  = '{32'h00309093, 64'd3,                 64'd77,    64'h100C,              64'd3,                 64'd3,                 CMD_OPIMM,   3'd1, 7'h00,    5'd1,  1'b0};
    vecs[4]  = '{32'h402081B3, 64'd10,                64'd20,    64'h1010,              64'd10,                64'd20,                CMD_OP,      3'd0, 7'h20,    5'd3,  1'b0};
    vecs[5]  = '{32'h123450B7, 64'd55,                64'd66,    64'h1014,              64'd0,                 64'h12345000,          CMD_LUI,     3'd0, 7'h00,    5'd1,  1'b0};
    vecs[6]  = '{32'h80000117, 64'd1,                 64'd2,     64'h8000000000000040,  64'h8000000000000040,  64'hFFFFFFFF80000000,  CMD_AUIPC,   3'd0, 7'h00,    5'd2,  1'b0};
    vecs[7]  = '{32'h00209463, 64'd42,                64'd43,    64'h1018,              64'd42,                64'd43,                CMD_BRANCH,  3'd0, 7'h20,    5'd0,  1'b0};
    vecs[8]  = '{32'hFF813083, 64'h2000,              64'd9,     64'h101C,              64'h2000,              64'hFFFFFFFFFFFFFFF8,  CMD_MEM,     3'd0, 7'h00,    5'd1,  1'b0};
    vecs[9]  = '{32'hFE113C23, 64'h3000,              64'd9,     64'h1020,              64'h3000,              64'hFFFFFFFFFFFFFFF8,  CMD_MEM,     3'd0, 7'h00,    5'd0,  1'b0};
    vecs[10] = '{32'h0000007F, 64'd11,                64'd12,    64'h1024,              64'd0,                 64'd0,                 CMD_ILLEGAL, 3'd0, 7'h00,    5'd0,  1'b1};
    vecs[11] = '{32'h00000FFF, 64'd13,                64'd14,    64'h1028,              64'd0,                 64'd0,                 CMD_ILLEGAL, 3'd0, 7'h00,    5'd0,  1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_in_ready", W'(in_ready), 1);
    check("rst_alu_a", alu_input_a, 0);
    check("rst_alu_cmd", W'(alu_cmd), 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", W'(out_rd), 0);
    check("rst_out_illegal", W'(out_illegal), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(i);

    // reset while an instruction sits in EXEC: it must vanish
    drive(vecs[2]);
    @(posedge clk); #1;
    scramble();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rexec_out_valid", W'(out_valid), 0);
    check("rexec_in_ready", W'(in_ready), 1);
    check("rexec_state", W'(dbg_state), W'(ST_IDLE));
    check("rexec_alu_a", alu_input_a, 0);
    check("rexec_alu_b", alu_input_b, 0);
    check("rexec_alu_cmd", W'(alu_cmd), 0);
    check("rexec_alu_f3", W'(alu_funct3), 0);
    check("rexec_alu_f7", W'(alu_funct7), 0);
    @(posedge clk); #1;

    // backpressure in DONE, competing in_valid ignored, then handoff + accept
    out_ready = 1'b0;
    drive(vecs[0]);
    exp_q.push_back(expect_of(vecs[0]));
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #1;
    drive(vecs[3]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", k), W'(out_valid), 1);
      check($sformatf("bp%0d_in_ready", k), W'(in_ready), 0);
      check($sformatf("bp%0d_result", k), out_result,
            alu_model(vecs[0].a, vecs[0].b, vecs[0].f7, vecs[0].f3, vecs[0].cmd));
      @(posedge clk); #1;
    end
    drive(vecs[1]);
    out_ready = 1'b1;
    exp_q.push_back(expect_of(vecs[1]));
    @(negedge clk);
    check("handoff_in_ready", W'(in_ready), 1);
    @(posedge clk); #1;
    scramble();
    @(negedge clk);
    check("handoff_state", W'(dbg_state), W'(ST_EXEC));
    check_alu(vecs[1], "handoff");
    @(posedge clk); #1;
    @(negedge clk);
    check("handoff_out_valid", W'(out_valid), 1);
    @(posedge clk); #1;

    // random replay of the table
    for (int n = 0; n < 20; n++) run_vec($urandom_range(0, 11));

    repeat (2) @(posedge clk);
    check("queue_drained", W'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
